mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the pipeline, sitting directly after the execute stage and consuming its results (ALU result, immediate memory address, store data, destination register, control word). It latches one execute result per handshake, runs a load or store against the data memory through a request/acknowledge interface with a bounded wait, and emits a single-cycle write-back record. A stall signal back-pressures the execute stage while a memory access is outstanding.

## Interface
- TIMEOUT, 15: maximum cycles mem_req stays asserted without mem_ack before the access is aborted (≥ 2)
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  execute result present this cycle
- in_ready  out  1  stage can accept a result this cycle
- stall  out  1  in_valid & ~in_ready
- ex_alu_out  in  32  ALU result
- ex_imm_addr  in  32  memory address
- ex_store_data  in  32  store data
- ex_dest  in  5  destination register
- ex_controls  in  32  control word: [21:20] mem op (00 none, 01 load, 10 store, 11 treated as none), [19] register write
- mem_req  out  1  memory request
- mem_we  out  1  1 = store, 0 = load; valid while mem_req
- mem_addr  out  32  {ex_imm_addr[31:2], 2'b00}
- mem_wdata  out  32  store data
- mem_ack  in  1  memory completes the current request this cycle
- mem_rdata  in  32  load data, valid with mem_ack
- wb_valid  out  1  write-back strobe, one cycle
- wb_dest  out  5  write-back register
- wb_data  out  32  write-back value
- err  out  1  sticky timeout flag

## Operation
- States: IDLE, REQ, WB. in_ready = 1 in IDLE and WB, 0 in REQ.
- Accept = in_valid & in_ready. On accept, latch address, store data, ALU result, dest, mem op, reg-write bit.
  - mem op load/store → REQ; otherwise → WB.
- REQ: mem_req = 1; mem_we, mem_addr, mem_wdata constant until exit.
  - mem_ack: load captures mem_rdata as wb_data → WB; store → WB.
  - No ack: wait counter increments; when the counter reaches TIMEOUT-1 with no ack → IDLE, err set, no write-back.
  - Counter cleared on every REQ entry.
- WB: wb_valid = reg-write bit & ~store; wb_data = load data for loads, ALU result otherwise; wb_dest = latched dest.
  - Accept in WB → REQ or WB per the new op. No accept → IDLE.
- wb_dest and wb_data hold their last values when wb_valid = 0.
- mem_ack outside REQ is ignored.
- Address bits [1:0] are dropped. No misalignment error.
- err clears only on reset.

## Timing
- Reset, asynchronous: state IDLE; mem_req, mem_we, wb_valid, err = 0; mem_addr, mem_wdata, wb_dest, wb_data = 0; counter = 0; in_ready = 1.
- Non-memory op: wb_valid high in the cycle after accept. Back-to-back ALU ops sustain one per cycle.
- Memory op: mem_req rises the cycle after accept. An ack in the first REQ cycle is legal. wb_valid follows one cycle after ack.
- Load latency is 2 + (ack wait cycles).
- Ack arriving in the same cycle as the timeout limit: ack wins and err is not set.
- Maximum mem_req duration without ack: exactly TIMEOUT cycles, then mem_req = 0 the next cycle.
- Reset mid-REQ: mem_req drops immediately. The transaction is lost, with no write-back and no err. A late ack after reset is ignored.
- in_ready and stall are combinational from state and in_valid only. There is no combinational path from mem_ack to in_ready.

## Test plan
- ALU op, controls[21:20]=00, [19]=1, alu_out=0x1234, dest=5, accepted at cycle 0 → wb_valid=1 at cycle 1, wb_data=0x1234, wb_dest=5, mem_req never asserted; three consecutive ALU ops give three consecutive wb_valid pulses.
- Load from ex_imm_addr=0x103, dest=9; memory acks on the 3rd REQ cycle with rdata=0xDEADBEEF → mem_addr=0x100, mem_we=0, stall high while REQ, wb_valid one cycle after ack with wb_data=0xDEADBEEF, wb_dest=9.
- Store with addr=0x40, data=0xA5A5A5A5, [19]=1, ack in first REQ cycle → mem_we=1, mem_wdata=0xA5A5A5A5 for one cycle, no wb_valid, in_ready back at 1 two cycles after accept.
- Load with no ack (TIMEOUT=15) → mem_req high exactly 15 cycles, err=1 after, no wb_valid; subsequent ALU op completes normally and err stays 1.
- Ack coincident with the last allowed cycle → load completes, err=0; stray mem_ack while IDLE → no effect.
- rst_n pulsed low during the 2nd REQ cycle → mem_req=0 immediately, all outputs at reset values, late ack ignored, next accepted op behaves normally.

Source files
------------

// File: rtl/mem_stage_if.sv
// -----------------------------------------------------------------------------
// mem_stage_if
// Request/acknowledge bus between the memory-access stage and data memory.
//   mem_req   : stage -> memory, request outstanding
//   mem_we    : stage -> memory, 1 = store, 0 = load (meaningful while mem_req)
//   mem_addr  : stage -> memory, word-aligned address
//   mem_wdata : stage -> memory, store data
//   mem_ack   : memory -> stage, current request completes this cycle
//   mem_rdata : memory -> stage, load data, valid with mem_ack
// master = pipeline stage side, slave = memory side.
// -----------------------------------------------------------------------------
interface mem_stage_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
// Memory-access pipeline stage. Takes one execute result per in_valid/in_ready
// handshake, performs a load or store over the mem bus with a bounded wait of
// TIMEOUT request cycles, and produces a one-cycle write-back record.
//   clk, rst_n        : clock, asynchronous active-low reset
//   in_valid/in_ready : execute-result handshake; stall = in_valid & ~in_ready
//   ex_*              : execute results (ALU result, address, store data,
//                       destination, control word [21:20] mem op, [19] reg write)
//   mem               : data-memory bus (master side)
//   wb_valid/dest/data: write-back record, dest/data hold when wb_valid = 0
//   err               : sticky access-timeout flag, cleared only by reset
// -----------------------------------------------------------------------------
module mem_stage #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        stall,
    input  logic [31:0] ex_alu_out,
    input  logic [31:0] ex_imm_addr,
    input  logic [31:0] ex_store_data,
    input  logic [4:0]  ex_dest,
    input  logic [31:0] ex_controls,
    mem_stage_if.master mem,
    output logic        wb_valid,
    output logic [4:0]  wb_dest,
    output logic [31:0] wb_data,
    output logic        err
);

    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WB   = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [4:0]        dest_q, dest_d;
    logic              wreg_q, wreg_d;
    logic              wb_valid_q, wb_valid_d;
    logic [4:0]        wb_dest_q, wb_dest_d;
    logic [31:0]       wb_data_q, wb_data_d;
    logic              err_q, err_d;

    logic              accept;
    logic              is_load, is_store;

    // Control bits and address bits this stage does not look at.
    logic unused_inputs;
    assign unused_inputs = ^{ex_controls[31:22], ex_controls[18:0], ex_imm_addr[1:0]};

    // Op code 2'b11 falls through as a plain ALU op.
    assign is_load  = (ex_controls[21:20] == 2'b01);
    assign is_store = (ex_controls[21:20] == 2'b10);

    // Ready depends on state only, so mem_ack never reaches in_ready combinationally.
    assign in_ready = (state_q != REQ);
    assign stall    = in_valid & ~in_ready;
    assign accept   = in_valid & in_ready;

    assign mem.mem_req   = (state_q == REQ);
    assign mem.mem_we    = (state_q == REQ) & we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;

    assign wb_valid = wb_valid_q;
    assign wb_dest  = wb_dest_q;
    assign wb_data  = wb_data_q;
    assign err      = err_q;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned, which would infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        dest_d     = dest_q;
        wreg_d     = wreg_q;
        wb_valid_d = 1'b0;
        wb_dest_d  = wb_dest_q;
        wb_data_d  = wb_data_q;
        err_d      = err_q;

        unique case (state_q)
            IDLE, WB: begin
                if (accept) begin
                    dest_d = ex_dest;
                    wreg_d = ex_controls[19];
                    if (is_load || is_store) begin
                        state_d = REQ;
                        cnt_d   = '0;
                        addr_d  = {ex_imm_addr[31:2], 2'b00};
                        wdata_d = ex_store_data;
                        we_d    = is_store;
                    end else begin
                        // ALU result goes straight into the write-back record.
                        state_d = WB;
                        if (ex_controls[19]) begin
                            wb_valid_d = 1'b1;
                            wb_dest_d  = ex_dest;
                            wb_data_d  = ex_alu_out;
                        end
                    end
                end else begin
                    state_d = IDLE;
                end
            end

            REQ: begin
                // Ack is tested first so an ack on the last allowed cycle wins.
                if (mem.mem_ack) begin
                    state_d = WB;
                    if (wreg_q && !we_q) begin
                        wb_valid_d = 1'b1;
                        wb_dest_d  = dest_q;
                        wb_data_d  = mem.mem_rdata;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            dest_q     <= '0;
            wreg_q     <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_dest_q  <= '0;
            wb_data_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            dest_q     <= dest_d;
            wreg_q     <= wreg_d;
            wb_valid_q <= wb_valid_d;
            wb_dest_q  <= wb_dest_d;
            wb_data_q  <= wb_data_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage
// Directed bench for mem_stage: a table of per-cycle input/expected-output
// records followed by hand-written sequences for timeout, ack on the last
// allowed cycle, and reset in the middle of a request.
// Inputs are driven on the falling edge; outputs are sampled on the falling
// edge after the rising edge that consumed the inputs.
// -----------------------------------------------------------------------------
module tb_mem_stage;

    localparam int unsigned TIMEOUT = 15;

    localparam logic [31:0] C_NOP = 32'h0000_0000;
    localparam logic [31:0] C_ALU = 32'h0008_0000;
    localparam logic [31:0] C_X11 = 32'h0038_0000;
    localparam logic [31:0] C_LD  = 32'h0018_0000;
    localparam logic [31:0] C_ST  = 32'h0028_0000;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        stall;
    logic [31:0] ex_alu_out;
    logic [31:0] ex_imm_addr;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_dest;
    logic [31:0] ex_controls;
    logic        wb_valid;
    logic [4:0]  wb_dest;
    logic [31:0] wb_data;
    logic        err;

    mem_stage_if bus ();

    mem_stage #(.TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .stall         (stall),
        .ex_alu_out    (ex_alu_out),
        .ex_imm_addr   (ex_imm_addr),
        .ex_store_data (ex_store_data),
        .ex_dest       (ex_dest),
        .ex_controls   (ex_controls),
        .mem           (bus),
        .wb_valid      (wb_valid),
        .wb_dest       (wb_dest),
        .wb_data       (wb_data),
        .err           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [31:0] ctrl, input logic [31:0] alu,
                         input logic [31:0] addr, input logic [31:0] sdata, input logic [4:0] dest);
        in_valid      = v;
        ex_controls   = ctrl;
        ex_alu_out    = alu;
        ex_imm_addr   = addr;
        ex_store_data = sdata;
        ex_dest       = dest;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".mem_req"},   {31'd0, bus.mem_req}, 32'd0);
        check({tag, ".mem_we"},    {31'd0, bus.mem_we},  32'd0);
        check({tag, ".mem_addr"},  bus.mem_addr,         32'd0);
        check({tag, ".mem_wdata"}, bus.mem_wdata,        32'd0);
        check({tag, ".wb_valid"},  {31'd0, wb_valid},    32'd0);
        check({tag, ".wb_dest"},   {27'd0, wb_dest},     32'd0);
        check({tag, ".wb_data"},   wb_data,              32'd0);
        check({tag, ".err"},       {31'd0, err},         32'd0);
        check({tag, ".in_ready"},  {31'd0, in_ready},    32'd1);
    endtask

    typedef struct {
        logic        valid;
        logic [31:0] ctrl;
        logic [31:0] alu;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [4:0]  dest;
        logic        ack;
        logic [31:0] rdata;
        logic        e_wbv;
        logic [4:0]  e_wdest;
        logic [31:0] e_wdata;
        logic        e_req;
        logic        e_we;
        logic [31:0] e_maddr;
        logic [31:0] e_mwdata;
        logic        e_rdy;
        logic        e_err;
    } vec_t;

    vec_t vecs [16];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          n_req;
        bit          saw_wb;

        //            v  ctrl   alu           addr          sdata         dst ack rdata          wbv wdst wdata         req we maddr         mwdata        rdy err
        vecs[0]  = '{1, C_ALU, 32'h0000_1234, 32'h0,        32'h0,        5,  0, 32'h0,         1,  5,  32'h0000_1234, 0, 0, 32'h0,        32'h0,        1, 0};
        vecs[1]  = '{1, C_ALU, 32'h0000_1111, 32'h0,        32'h0,        1,  0, 32'h0,         1,  1,  32'h0000_1111, 0, 0, 32'h0,        32'h0,        1, 0};
        vecs[2]  = '{1, C_ALU, 32'h0000_2222, 32'h0,        32'h0,        2,  0, 32'h0,         1,  2,  32'h0000_2222, 0, 0, 32'h0,        32'h0,        1, 0};
        vecs[3]  = '{1, C_ALU, 32'h0000_3333, 32'h0,        32'h0,        3,  0, 32'h0,         1,  3,  32'h0000_3333, 0, 0, 32'h0,        32'h0,        1, 0};
        vecs[4]  = '{0, C_NOP, 32'h0,         32'h0,        32'h0,        0,  0, 32'h0,         0,  3,  32'h0000_3333, 0, 0, 32'h0,        32'h0,        1, 0};
        vecs[5]  = '{1, C_X11, 32'h0000_7777, 32'h0,        32'h0,        7,  0, 32'h0,         1,  7,  32'h0000_7777, 0, 0, 32'h0,        32'h0,        1, 0};
        vecs[6]  = '{1, C_NOP, 32'h0000_0BAD, 32'h0,        32'h0,        8,  0, 32'h0,         0,  7,  32'h0000_7777, 0, 0, 32'h0,        32'h0,        1, 0};
        vecs[7]  = '{1, C_LD,  32'h0000_5555, 32'h0000_0103, 32'h0,       9,  0, 32'h0,         0,  7,  32'h0000_7777, 1, 0, 32'h0000_0100, 32'h0,       0, 0};
        vecs[8]  = '{1, C_ALU, 32'h0000_FFFF, 32'h0,        32'h0,        31, 0, 32'h0,         0,  7,  32'h0000_7777, 1, 0, 32'h0000_0100, 32'h0,       0, 0};
        vecs[9]  = '{1, C_ALU, 32'h0000_FFFF, 32'h0,        32'h0,        31, 0, 32'h0,         0,  7,  32'h0000_7777, 1, 0, 32'h0000_0100, 32'h0,       0, 0};
        vecs[10] = '{1, C_ALU, 32'h0000_FFFF, 32'h0,        32'h0,        31, 1, 32'hDEAD_BEEF, 1,  9,  32'hDEAD_BEEF, 0, 0, 32'h0000_0100, 32'h0,       1, 0};
        vecs[11] = '{1, C_ALU, 32'h0000_FFFF, 32'h0,        32'h0,        31, 0, 32'h0,         1,  31, 32'h0000_FFFF, 0, 0, 32'h0000_0100, 32'h0,       1, 0};
        vecs[12] = '{1, C_ST,  32'h0,         32'h0000_0040, 32'hA5A5_A5A5, 4, 0, 32'h0,        0,  31, 32'h0000_FFFF, 1, 1, 32'h0000_0040, 32'hA5A5_A5A5, 0, 0};
        vecs[13] = '{0, C_NOP, 32'h0,         32'h0,        32'h0,        0,  1, 32'h0,         0,  31, 32'h0000_FFFF, 0, 0, 32'h0000_0040, 32'hA5A5_A5A5, 1, 0};
        vecs[14] = '{0, C_NOP, 32'h0,         32'h0,        32'h0,        0,  0, 32'h0,         0,  31, 32'h0000_FFFF, 0, 0, 32'h0000_0040, 32'hA5A5_A5A5, 1, 0};
        vecs[15] = '{0, C_NOP, 32'h0,         32'h0,        32'h0,        0,  1, 32'h0000_0099, 0,  31, 32'h0000_FFFF, 0, 0, 32'h0000_0040, 32'hA5A5_A5A5, 1, 0};

        rst_n = 1'b0;
        drive(0, C_NOP, 0, 0, 0, 0);
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;
        tick();
        tick();
        check_reset_state("reset");
        rst_n = 1'b1;

        // Table: one record per clock.
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].valid, vecs[i].ctrl, vecs[i].alu, vecs[i].addr, vecs[i].sdata, vecs[i].dest);
            bus.mem_ack   = vecs[i].ack;
            bus.mem_rdata = vecs[i].rdata;
            tick();
            check($sformatf("v%0d.wb_valid", i),  {31'd0, wb_valid},      {31'd0, vecs[i].e_wbv});
            check($sformatf("v%0d.wb_dest", i),   {27'd0, wb_dest},       {27'd0, vecs[i].e_wdest});
            check($sformatf("v%0d.wb_data", i),   wb_data,                vecs[i].e_wdata);
            check($sformatf("v%0d.mem_req", i),   {31'd0, bus.mem_req},   {31'd0, vecs[i].e_req});
            check($sformatf("v%0d.mem_we", i),    {31'd0, bus.mem_we},    {31'd0, vecs[i].e_we});
            check($sformatf("v%0d.mem_addr", i),  bus.mem_addr,           vecs[i].e_maddr);
            check($sformatf("v%0d.mem_wdata", i), bus.mem_wdata,          vecs[i].e_mwdata);
            check($sformatf("v%0d.in_ready", i),  {31'd0, in_ready},      {31'd0, vecs[i].e_rdy});
            check($sformatf("v%0d.err", i),       {31'd0, err},           {31'd0, vecs[i].e_err});
        end
        bus.mem_ack = 1'b0;

        // Timeout: load with no ack.
        drive(1, C_LD, 0, 32'h0000_0200, 0, 10);
        tick();
        drive(1, C_ALU, 32'h0000_0001, 0, 0, 1);
        #1;
        check("to.stall_in_req", {31'd0, stall},    32'd1);
        check("to.ready_in_req", {31'd0, in_ready}, 32'd0);
        drive(0, C_NOP, 0, 0, 0, 0);
        n_req  = 0;
        saw_wb = 1'b0;
        while (bus.mem_req && n_req < 40) begin
            n_req++;
            tick();
            if (wb_valid) saw_wb = 1'b1;
        end
        check("to.req_cycles", n_req,                 TIMEOUT);
        check("to.req_low",    {31'd0, bus.mem_req},  32'd0);
        check("to.err_set",    {31'd0, err},          32'd1);
        check("to.no_wb",      {31'd0, saw_wb},       32'd0);

        drive(1, C_ALU, 32'h0000_ABCD, 0, 0, 12);
        tick();
        drive(0, C_NOP, 0, 0, 0, 0);
        check("to.alu_wbv",   {31'd0, wb_valid}, 32'd1);
        check("to.alu_data",  wb_data,           32'h0000_ABCD);
        check("to.alu_dest",  {27'd0, wb_dest},  32'd12);
        check("to.err_stick", {31'd0, err},      32'd1);
        tick();

        // Reset clears err and all outputs.
        rst_n = 1'b0;
        #1;
        check_reset_state("rst2");
        tick();
        rst_n = 1'b1;

        // Ack on the last allowed request cycle.
        drive(1, C_LD, 0, 32'h0000_0300, 0, 11);
        tick();
        drive(0, C_NOP, 0, 0, 0, 0);
        for (int k = 0; k < TIMEOUT - 1; k++) tick();
        check("last.req_still", {31'd0, bus.mem_req}, 32'd1);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hCAFE_F00D;
        tick();
        bus.mem_ack   = 1'b0;
        check("last.wbv",  {31'd0, wb_valid},    32'd1);
        check("last.data", wb_data,              32'hCAFE_F00D);
        check("last.dest", {27'd0, wb_dest},     32'd11);
        check("last.err",  {31'd0, err},         32'd0);
        check("last.req",  {31'd0, bus.mem_req}, 32'd0);
        tick();

        // Reset during the second request cycle.
        drive(1, C_LD, 0, 32'h0000_0404, 0, 13);
        tick();
        drive(0, C_NOP, 0, 0, 0, 0);
        tick();
        check("mid.req_before", {31'd0, bus.mem_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_state("mid");
        tick();
        rst_n = 1'b1;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h0000_0001;
        tick();
        bus.mem_ack   = 1'b0;
        check("mid.late_ack_wbv", {31'd0, wb_valid},    32'd0);
        check("mid.late_ack_req", {31'd0, bus.mem_req}, 32'd0);
        check("mid.late_ack_err", {31'd0, err},         32'd0);
        drive(1, C_ALU, 32'h0000_0055, 0, 0, 14);
        tick();
        drive(0, C_NOP, 0, 0, 0, 0);
        check("mid.next_wbv",  {31'd0, wb_valid}, 32'd1);
        check("mid.next_data", wb_data,           32'h0000_0055);
        check("mid.next_dest", {27'd0, wb_dest},  32'd14);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
